keypad_move_scanner: RTL



---
 rtl/keypad_move_scanner_if.sv | 33 +++
 rtl/keypad_move_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_move_scanner_if.sv
// keypad_move_scanner_if
// Bundles the keypad matrix pins, the board/game status inputs and the
// key/move event outputs of the keypad move scanner.
//   key_col     : column drive, active-low one-hot (scanner -> keypad)
//   key_row     : row sense, active-high, row 0 = top (keypad -> scanner)
//   board       : cell occupancy, cell k uses bit 19-2k (O) and 18-2k (X)
//   game_en     : high while a game is in progress
//   key_data    : accepted key code, held while the key is down
//   key_strobe  : one-cycle pulse per accepted press
//   move_strobe : one-cycle pulse, legal move on cell key_data
//   move_reject : one-cycle pulse, occupied cell or no game running
//   clear_req   : one-cycle pulse on '*'
interface keypad_move_scanner_if;
    logic [2:0]  key_col;
    logic [3:0]  key_row;
    logic [17:0] board;
    logic        game_en;
    logic [3:0]  key_data;
    logic        key_strobe;
    logic        move_strobe;
    logic        move_reject;
    logic        clear_req;

    modport master (
        output key_col, key_data, key_strobe, move_strobe, move_reject, clear_req,
        input  key_row, board, game_en
    );

    modport slave (
        input  key_col, key_data, key_strobe, move_strobe, move_reject, clear_req,
        output key_row, board, game_en
    );
endinterface

// File: rtl/keypad_move_scanner.sv
// keypad_move_scanner
// Scans a 4x3 keypad, debounces whole scan frames and turns each accepted
// press into a key code plus a move / reject / clear event for the
// game-state block.
//   clk, rst : clock, synchronous active-high reset
//   kp       : keypad_move_scanner_if.master (matrix pins, board status,
//              key/move event outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no key accepted; waiting for a stable code 1..12
// PRESSED | key accepted and held; waiting for a stable empty frame
module keypad_move_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_move_scanner_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic {IDLE, PRESSED} state_t;

    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic [11:0]      frame_q;
    logic [11:0]      frame_now;
    logic [3:0]       prev_raw_q, prev_raw_d;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [3:0]       raw;
    logic [3:0]       ones;
    logic             last_dwell;
    logic             frame_done;
    logic             occupied;

    state_t           state_q, state_d;
    logic [3:0]       key_data_q, key_data_d;
    logic             key_strobe_q, key_strobe_d;
    logic             move_strobe_q, move_strobe_d;
    logic             move_reject_q, move_reject_d;
    logic             clear_req_q, clear_req_d;

    assign last_dwell = (dwell_q == DWELL_LAST);
    assign frame_done = last_dwell && (col_q == 2'd2);

    // Frame bit 3r+c is key (row r, column c); the code of that key is bit+1.
    always_comb begin
        frame_now = frame_q;
        for (int r = 0; r < 4; r++) begin
            case (col_q)
                2'd0:    frame_now[3*r]     = kp.key_row[r];
                2'd1:    frame_now[3*r + 1] = kp.key_row[r];
                2'd2:    frame_now[3*r + 2] = kp.key_row[r];
                default: ;
            endcase
        end
    end

    always_comb begin
        ones = '0;
        raw  = '0;
        for (int i = 0; i < 12; i++) begin
            if (frame_now[i]) begin
                ones = ones + 4'd1;
                raw  = 4'(i + 1);
            end
        end
        if (ones > 4'd1) begin
            raw = 4'd15;
        end
    end

    always_comb begin
        prev_raw_d   = prev_raw_q;
        stable_cnt_d = stable_cnt_q;
        if (frame_done) begin
            if (raw == prev_raw_q) begin
                if (stable_cnt_q != CNT_MAX) begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end else begin
                prev_raw_d   = raw;
                stable_cnt_d = CNT_W'(1);
            end
        end
    end

    always_comb begin
        occupied = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (prev_raw_d == 4'(k)) begin
                occupied = kp.board[19 - 2*k] | kp.board[18 - 2*k];
            end
        end
    end

    // Decisions are taken only on the frame-complete cycle, using the
    // debounce values being written on that edge, so the strobes appear
    // one cycle after the deciding frame completes.
    always_comb begin
        state_d       = state_q;
        key_data_d    = key_data_q;
        key_strobe_d  = 1'b0;
        move_strobe_d = 1'b0;
        move_reject_d = 1'b0;
        clear_req_d   = 1'b0;
        if (frame_done && (stable_cnt_d == CNT_MAX)) begin
            case (state_q)
                IDLE: begin
                    if ((prev_raw_d >= 4'd1) && (prev_raw_d <= 4'd12)) begin
                        state_d      = PRESSED;
                        key_data_d   = prev_raw_d;
                        key_strobe_d = 1'b1;
                        if (prev_raw_d <= 4'd9) begin
                            if (kp.game_en && !occupied) begin
                                move_strobe_d = 1'b1;
                            end else begin
                                move_reject_d = 1'b1;
                            end
                        end else if (prev_raw_d == 4'd10) begin
                            clear_req_d = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (prev_raw_d == 4'd0) begin
                        state_d    = IDLE;
                        key_data_d = 4'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q       <= '0;
            col_q         <= 2'd0;
            frame_q       <= '0;
            prev_raw_q    <= 4'd0;
            stable_cnt_q  <= '0;
            state_q       <= IDLE;
            key_data_q    <= 4'd0;
            key_strobe_q  <= 1'b0;
            move_strobe_q <= 1'b0;
            move_reject_q <= 1'b0;
            clear_req_q   <= 1'b0;
        end else begin
            if (last_dwell) begin
                dwell_q <= '0;
                col_q   <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
                frame_q <= frame_done ? 12'd0 : frame_now;
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
            prev_raw_q    <= prev_raw_d;
            stable_cnt_q  <= stable_cnt_d;
            state_q       <= state_d;
            key_data_q    <= key_data_d;
            key_strobe_q  <= key_strobe_d;
            move_strobe_q <= move_strobe_d;
            move_reject_q <= move_reject_d;
            clear_req_q   <= clear_req_d;
        end
    end

    assign kp.key_col     = ~(3'b001 << col_q);
    assign kp.key_data    = key_data_q;
    assign kp.key_strobe  = key_strobe_q;
    assign kp.move_strobe = move_strobe_q;
    assign kp.move_reject = move_reject_q;
    assign kp.clear_req   = clear_req_q;

endmodule
